// File: rtl/decode_queue.sv
// RV32I decode stage: splits each accepted instruction into fields, format and
// immediate at push time and buffers the results in a DEPTH-entry circular FIFO.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_fmt,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec_p0;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  function automatic logic [2:0] fmt_of(input logic [6:0] op);
    case (op)
      7'b0110011:                                     return 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd1;
      7'b0100011:                                     return 3'd2;
      7'b1100011:                                     return 3'd3;
      7'b0110111, 7'b0010111:                         return 3'd4;
      7'b1101111:                                     return 3'd5;
      default:                                        return 3'd7;
    endcase
  endfunction

  // Immediate is assembled as a signed 32-bit value, then widened by a signed cast.
  function automatic logic signed [XLEN-1:0] imm_of(input logic [31:0] ins,
                                                     input logic [2:0]  fmt);
    logic signed [31:0] v;
    v = '0;
    case (fmt)
      3'd1:    v = {{20{ins[31]}}, ins[31:20]};
      3'd2:    v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd3:    v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd4:    v = {ins[31:12], 12'b0};
      3'd5:    v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && out_ready;

  always_comb begin
    dec_p0        = '0;
    dec_p0.opcode = in_instr[6:0];
    dec_p0.funct3 = in_instr[14:12];
    dec_p0.funct7 = in_instr[31:25];
    dec_p0.rd     = in_instr[11:7];
    dec_p0.rs1    = in_instr[19:15];
    dec_p0.rs2    = in_instr[24:20];
    dec_p0.fmt    = fmt_of(in_instr[6:0]);
    dec_p0.imm    = imm_of(in_instr, dec_p0.fmt);
    dec_p0.pc     = in_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec_p0;
  end

  assign head       = empty ? '0 : mem[rd_ptr];
  assign out_valid  = !empty;
  assign out_opcode = head.opcode;
  assign out_funct3 = head.funct3;
  assign out_funct7 = head.funct7;
  assign out_rd     = head.rd;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_fmt    = head.fmt;
  assign out_imm    = head.imm;
  assign out_pc     = head.pc;
  assign out_count  = count;

endmodule
